// File: rtl/fsm_cmd_driver_if.sv
// Host request channel and downstream-FSM command/echo channel of fsm_cmd_driver.
// master = host side (also stands in for the downstream FSM's state echo); slave = the driver.
interface fsm_cmd_driver_if;
  logic       req_valid;
  logic [2:0] req_target;
  logic       req_ready;
  logic [2:0] state_in;
  logic [2:0] cmd_out;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output req_valid, req_target, state_in,
    input  req_ready, cmd_out, cmd_valid, busy, done, err, err_code
  );

  modport slave (
    input  req_valid, req_target, state_in,
    output req_ready, cmd_out, cmd_valid, busy, done, err, err_code
  );
endinterface

// File: rtl/fsm_cmd_driver.sv
// Walks the downstream control FSM around the ring 0->1->2->3->0 one hop at a time,
// waiting for each state echo and reporting illegal targets, timeouts and bad echoes.
module fsm_cmd_driver #(
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_cmd_driver_if.slave      bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] EC_NONE  = 2'd0;
  localparam logic [1:0] EC_ILLEG = 2'd1;
  localparam logic [1:0] EC_TMO   = 2'd2;
  localparam logic [1:0] EC_ECHO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [2:0]    r_cur;
  logic [2:0]    r_tgt;
  logic [2:0]    r_hop;
  logic [2:0]    r_cmd;
  logic [TW-1:0] r_tmr;
  logic [1:0]    r_ecode;
  logic [1:0]    w_ecode_nxt;
  logic          r_ready;

  logic          w_accept;
  logic          w_match;
  logic          w_stall;
  logic          w_tmo;
  logic [2:0]    w_base;
  logic [2:0]    w_hop_nxt;

  // r_ready mirrors "state is IDLE" but stays low through reset.
  assign w_accept = (r_state == S_IDLE) && r_ready && bus.req_valid;
  assign w_match  = (bus.state_in == r_hop);
  assign w_stall  = (bus.state_in == r_cur);
  assign w_tmo    = (r_tmr == TMO_LAST);

  // Next hop is always computed from the value cur will hold when ISSUE is entered.
  assign w_base    = (r_state == S_IDLE) ? bus.state_in : r_hop;
  assign w_hop_nxt = (w_base + 3'd1) & 3'b011;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_ecode_nxt = r_ecode;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ecode_nxt = EC_NONE;
          if (bus.req_target > 3'd3) begin
            w_nxt       = S_ERR;
            w_ecode_nxt = EC_ILLEG;
          end else if (bus.state_in > 3'd3) begin
            w_nxt       = S_ERR;
            w_ecode_nxt = EC_ECHO;
          end else if (bus.req_target == bus.state_in) begin
            w_nxt = S_DONE;
          end else begin
            w_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT: begin
        if (w_match) begin
          w_nxt = (r_hop == r_tgt) ? S_DONE : S_ISSUE;
        end else if (w_stall) begin
          if (w_tmo) begin
            w_nxt       = S_ERR;
            w_ecode_nxt = EC_TMO;
          end
        end else begin
          w_nxt       = S_ERR;
          w_ecode_nxt = EC_ECHO;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      S_ERR:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur   <= '0;
      r_tgt   <= '0;
      r_hop   <= '0;
      r_cmd   <= '0;
      r_tmr   <= '0;
      r_ecode <= EC_NONE;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_nxt == S_IDLE);
      r_ecode <= w_ecode_nxt;
      if (w_accept) begin
        r_tgt <= bus.req_target;
        r_cur <= bus.state_in;
      end
      if (r_state == S_WAIT && w_match) r_cur <= r_hop;
      if (w_nxt == S_ISSUE) begin
        r_hop <= w_hop_nxt;
        r_cmd <= w_hop_nxt;
      end
      // tmr counts stalled WAIT cycles; hitting TMO_LAST on a stall ends the hop.
      if (r_state == S_ISSUE)
        r_tmr <= '0;
      else if (r_state == S_WAIT && !w_match && w_stall && !w_tmo)
        r_tmr <= r_tmr + 1'b1;
    end
  end

  always_comb begin
    bus.req_ready = r_ready;
    bus.cmd_out   = r_cmd;
    bus.cmd_valid = (r_state == S_ISSUE);
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_DONE);
    bus.err       = (r_state == S_ERR);
    bus.err_code  = r_ecode;
  end

endmodule

// File: tb/tb_fsm_cmd_driver.sv
// Directed bench for fsm_cmd_driver (TIMEOUT=4): multi-hop walks, wrap, errors, timeout, reset.
module tb_fsm_cmd_driver;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fsm_cmd_driver_if bus();

  fsm_cmd_driver #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns in cycle A+1.
  task automatic req(input logic [2:0] tgt, input logic [2:0] sin);
    bus.req_target = tgt;
    bus.state_in   = sin;
    bus.req_valid  = 1'b1;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_target = 3'd0;
    bus.state_in   = 3'd0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_cmd",   32'(bus.cmd_out), 0);
    chk("rst_cval",  32'(bus.cmd_valid), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_err",   32'(bus.err), 0);
    chk("rst_ecode", 32'(bus.err_code), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.req_ready), 1);

    // 0 -> 2: two hops
    req(3'd2, 3'd0);
    chk("t1_a1_cval", 32'(bus.cmd_valid), 1);
    chk("t1_a1_cmd",  32'(bus.cmd_out), 1);
    chk("t1_a1_busy", 32'(bus.busy), 1);
    chk("t1_a1_rdy",  32'(bus.req_ready), 0);
    bus.state_in = 3'd1;
    tick();
    chk("t1_a2_cval", 32'(bus.cmd_valid), 0);
    tick();
    chk("t1_a3_cval", 32'(bus.cmd_valid), 1);
    chk("t1_a3_cmd",  32'(bus.cmd_out), 2);
    bus.state_in = 3'd2;
    tick();
    chk("t1_a4_done", 32'(bus.done), 0);
    tick();
    chk("t1_a5_done",  32'(bus.done), 1);
    chk("t1_a5_ecode", 32'(bus.err_code), 0);
    tick();
    chk("t1_a6_done", 32'(bus.done), 0);
    chk("t1_a6_rdy",  32'(bus.req_ready), 1);

    // 3 -> 1 wraps through 0
    req(3'd1, 3'd3);
    chk("t2_a1_cmd", 32'(bus.cmd_out), 0);
    chk("t2_a1_cval", 32'(bus.cmd_valid), 1);
    bus.state_in = 3'd0;
    tick();
    tick();
    chk("t2_a3_cmd", 32'(bus.cmd_out), 1);
    chk("t2_a3_cval", 32'(bus.cmd_valid), 1);
    bus.state_in = 3'd1;
    tick();
    tick();
    chk("t2_a5_done", 32'(bus.done), 1);
    chk("t2_a5_cmd",  32'(bus.cmd_out), 1);
    tick();

    // Illegal target
    req(3'd5, 3'd1);
    chk("t3_a1_err",   32'(bus.err), 1);
    chk("t3_a1_ecode", 32'(bus.err_code), 1);
    chk("t3_a1_cval",  32'(bus.cmd_valid), 0);
    tick();
    chk("t3_a2_rdy",   32'(bus.req_ready), 1);
    chk("t3_a2_err",   32'(bus.err), 0);
    chk("t3_a2_ecode", 32'(bus.err_code), 1);

    // Target equals current state: done with no command
    req(3'd1, 3'd1);
    chk("t4_a1_done",  32'(bus.done), 1);
    chk("t4_a1_cval",  32'(bus.cmd_valid), 0);
    chk("t4_a1_ecode", 32'(bus.err_code), 0);
    chk("t4_a1_cmd",   32'(bus.cmd_out), 1);
    tick();

    // Out-of-range echo at accept
    req(3'd0, 3'd6);
    chk("t5_a1_err",   32'(bus.err), 1);
    chk("t5_a1_ecode", 32'(bus.err_code), 3);
    tick();

    // Timeout: no echo after issuing 1; stray request during WAIT is ignored
    req(3'd1, 3'd0);
    chk("t6_issue_cmd", 32'(bus.cmd_out), 1);
    bus.req_valid  = 1'b1;
    bus.req_target = 3'd3;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t6_i%0d_err", i), 32'(bus.err), 0);
      chk($sformatf("t6_i%0d_busy", i), 32'(bus.busy), 1);
      chk($sformatf("t6_i%0d_cval", i), 32'(bus.cmd_valid), 0);
    end
    bus.req_valid = 1'b0;
    tick();
    chk("t6_i5_err",   32'(bus.err), 1);
    chk("t6_i5_ecode", 32'(bus.err_code), 2);
    chk("t6_i5_cmd",   32'(bus.cmd_out), 1);
    tick();

    // Bad echo while waiting for hop 2
    req(3'd3, 3'd0);
    bus.state_in = 3'd1;
    tick();
    tick();
    chk("t7_a3_cmd", 32'(bus.cmd_out), 2);
    bus.state_in = 3'd3;
    tick();
    chk("t7_a4_err", 32'(bus.err), 0);
    tick();
    chk("t7_a5_err",   32'(bus.err), 1);
    chk("t7_a5_ecode", 32'(bus.err_code), 3);
    tick();

    // Reset in WAIT, then a one-hop request
    req(3'd2, 3'd0);
    tick();
    chk("t8_wait_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    chk("t8_rst_busy",  32'(bus.busy), 0);
    chk("t8_rst_cmd",   32'(bus.cmd_out), 0);
    chk("t8_rst_ecode", 32'(bus.err_code), 0);
    chk("t8_rst_rdy",   32'(bus.req_ready), 0);
    rst = 1'b0;
    tick();
    chk("t8_post_rdy", 32'(bus.req_ready), 1);
    req(3'd1, 3'd0);
    chk("t8_a1_cmd", 32'(bus.cmd_out), 1);
    bus.state_in = 3'd1;
    tick();
    tick();
    chk("t8_a3_done", 32'(bus.done), 1);
    tick();
    chk("t8_a4_rdy", 32'(bus.req_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_cmd_driver.md
# fsm_cmd_driver

Command-side companion to the user-input-driven control FSM. It accepts a requested target state from a host over a valid/ready handshake and drives the FSM's 3-bit `user_input` one legal hop at a time around the ring 0→1→2→3→0. After each hop it waits for the FSM's echoed state before issuing the next. Illegal targets, timeouts and unexpected state echoes are reported instead of being forwarded, so the downstream FSM never sees an out-of-sequence command.

## Interface
- `TIMEOUT`, default 15: maximum WAIT cycles allowed per hop before error; legal range 2..255.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  host request valid.
- `req_target`  in  3  requested final state; only 0..3 are legal.
- `req_ready`  out  1  high only in IDLE.
- `state_in`  in  3  state echoed back by the downstream FSM.
- `cmd_out`  out  3  connects to the FSM `user_input`; holds the last issued value.
- `cmd_valid`  out  1  one-cycle strobe when `cmd_out` is updated.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  one-cycle pulse on failure.
- `err_code`  out  2  0 = none, 1 = illegal target, 2 = timeout, 3 = bad echo; held until the next accepted request.

## Operation
- Internal registers:
  - `cur` (3 b): believed current state.
  - `tgt` (3 b): latched target.
  - `hop` (3 b): command currently in flight.
  - `tmr`: width ceil(log2(TIMEOUT+1)).
- State machine states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `tgt`=`req_target`, set `cur`=`state_in`, clear `err_code`.
  - If `req_target`>3: go to ERR with code 1.
  - Else if `state_in`>3: go to ERR with code 3.
  - Else if `req_target`==`state_in`: go to DONE.
  - Else: go to ISSUE.
- ISSUE:
  - `hop`=(`cur`+1) mod 4; `cmd_out`=`hop`; `cmd_valid`=1.
  - Clear `tmr`; go to WAIT.
- WAIT:
  - `state_in`==`hop`: set `cur`=`hop`. Go to DONE if `hop`==`tgt`, else go to ISSUE.
  - `state_in`==`cur` (FSM not yet moved): `tmr`++. When `tmr` reaches TIMEOUT-1 without a match, go to ERR with code 2.
  - Any other `state_in` value: go to ERR with code 3.
- DONE: `done`=1 for one cycle, then go to IDLE.
- ERR: `err`=1 for one cycle, then go to IDLE.
- Arithmetic: the hop increment is 2-bit modulo, so 3→0 wraps. The only path from 3 to 1 is 3→0→1 (2 hops). Maximum path is 3 hops.
- All outputs are decoded from registered state or are registers. There is no combinational path from any input to any output.
- `req_valid` is ignored when not in IDLE; no request queueing.

## Timing
- Reset values: `req_ready`=0 during reset, 1 from the first cycle after `rst` deasserts. `cmd_out`=0, `cmd_valid`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0. `cur`, `tgt`, `hop`, `tmr`=0.
- Accept happens at edge A (`req_valid`&&`req_ready`):
  - Normal path: cycle A+1 is ISSUE (`cmd_valid`=1). WAIT starts at A+2.
  - Target equals current state: `done` at A+1; no command issued.
  - Illegal target or bad `state_in`: `err` at A+1.
- A match seen in a WAIT cycle leads to ISSUE or DONE on the next cycle.
- Per-hop best case is 2 cycles (ISSUE plus 1 WAIT).
- A single hop with an immediate echo gives `done` at A+3.
- Timeout: with no echo, `err` rises exactly TIMEOUT+1 cycles after the ISSUE cycle.
- `rst` asserted mid-operation: all outputs take reset values on the next edge; the in-flight hop is abandoned and `cmd_out` returns to 0.
- Back-to-back requests: the earliest next accept is the cycle after DONE/ERR (IDLE).

## Test plan
- Reset, then `state_in`=0 and request `req_target`=2: `cmd_out`=1 strobe at A+1, echo 1 at A+2, `cmd_out`=2 strobe at A+3, echo 2 at A+4, `done` at A+5, `err_code`=0.
- `state_in`=3, request target 1: commands 0 then 1 issued in order; `done` pulses; `cmd_out` ends at 1.
- Request target 5: `err` at A+1, `err_code`=1, no `cmd_valid` strobe, `req_ready` back high at A+2.
- `state_in` held at 0 after issuing 1, TIMEOUT=4: `err` at ISSUE+5 cycles, `err_code`=2.
- During WAIT for hop 2, echo 3: next cycle goes to ERR, `err_code`=3.
- Assert `rst` in WAIT: next cycle `busy`=0, `cmd_out`=0, `err_code`=0; a new request is accepted normally afterwards.
